// File: rtl/c2sif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c2sif_pkg
// Brief    : Shared function codes, return codes and driver FSM states for
//            the c2sif bus driver.
// Revision : 1.0 - initial release
// ============================================================================
package c2sif_pkg;

  // Function codes carried on c2s_fn
  localparam logic [7:0] FN_WRITE = 8'd0;
  localparam logic [7:0] FN_READ  = 8'd1;
  localparam logic [7:0] FN_PULSE = 8'd2;
  localparam logic [7:0] FN_WRALL = 8'd3;

  // Return codes presented on c2s_ret
  localparam logic [31:0] RET_OK    = 32'd0;
  localparam logic [31:0] RET_BADFN = 32'd1;
  localparam logic [31:0] RET_BADCH = 32'd2;

  // Driver sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_PULSE  = 3'd2,
    ST_ACK    = 3'd3,
    ST_IGNORE = 3'd4
  } drv_state_t;

endpackage : c2sif_pkg
`default_nettype wire

// File: rtl/c2sif_sync.sv
`default_nettype none
// ============================================================================
// Module   : c2sif_sync
// Brief    : Parametrised-width two-stage synchroniser, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module c2sif_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops so metastability settles before use
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : c2sif_sync
`default_nettype wire

// File: rtl/drv_c2sif_bus.sv
`default_nettype none
// ============================================================================
// Module   : drv_c2sif_bus
// Brief    : c2sif request bridge driving NCH lanes of W bits, with read-back,
//            timed pulse, write-all and error return codes.
// Revision : 1.0 - initial release
// ============================================================================
module drv_c2sif_bus
  import c2sif_pkg::*;
#(
  parameter int          ID        = 0,
  parameter int          NCH       = 4,
  parameter int          W         = 8,
  parameter int          PULSE_LEN = 4,
  parameter logic [31:0] RST_VAL   = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c2s_req,
  input  logic [7:0]         c2s_id,
  input  logic [7:0]         c2s_fn,
  input  logic [31:0]        c2s_data0,
  input  logic [31:0]        c2s_data1,
  output logic               c2s_ack,
  output logic [31:0]        c2s_ret,
  output logic [31:0]        c2s_rdata,
  output logic [NCH*W-1:0]   din,
  input  logic [NCH*W-1:0]   dout
);

  localparam int            CHW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int            CW       = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [W-1:0]  LANE_RST = RST_VAL[W-1:0];
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN - 1);

  logic                    w_req_s;
  logic [NCH*W-1:0]        w_dout_s;
  logic [NCH-1:0][W-1:0]   w_dout_lane;
  logic                    r_req_prev;
  logic [1:0]              r_settle;
  logic                    r_armed;
  logic                    w_req_rise;

  drv_state_t              r_state;
  drv_state_t              w_state_next;

  logic [7:0]              r_fn;
  logic [W-1:0]            r_data0;
  logic [31:0]             r_data1;
  logic [CHW-1:0]          w_ch;
  logic                    w_ch_bad;

  logic [NCH-1:0][W-1:0]   r_lane;
  logic [W-1:0]            r_saved;
  logic [CW-1:0]           r_cnt;
  logic [31:0]             r_ret;
  logic [31:0]             r_rdata;

  logic                    w_unused_data0;

  c2sif_sync #(.WIDTH(1)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (c2s_req),
    .q   (w_req_s)
  );

  c2sif_sync #(.WIDTH(NCH*W)) u_sync_dout (
    .clk (clk),
    .rst (rst),
    .d   (dout),
    .q   (w_dout_s)
  );

  assign w_dout_lane    = w_dout_s;
  assign w_ch           = r_data1[CHW-1:0];
  assign w_ch_bad       = (r_data1 >= 32'(NCH));
  assign w_unused_data0 = ^c2s_data0;

  // Edge detect on req; arming waits until the synchroniser has flushed its
  // reset value and seen req low, so a req held across reset is not taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_prev <= 1'b0;
      r_settle   <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_req_prev <= w_req_s;
      r_settle   <= {r_settle[0], 1'b1};
      if (r_settle[1] && !w_req_s)
        r_armed <= 1'b1;
    end
  end

  assign w_req_rise = r_armed && w_req_s && !r_req_prev;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_rise)
          w_state_next = (c2s_id == 8'(ID)) ? ST_EXEC : ST_IGNORE;
      end
      ST_EXEC: begin
        if (r_fn == FN_PULSE && !w_ch_bad) w_state_next = ST_PULSE;
        else                               w_state_next = ST_ACK;
      end
      ST_PULSE: begin
        if (r_cnt == '0) w_state_next = ST_ACK;
      end
      ST_ACK, ST_IGNORE: begin
        if (!w_req_s) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request latch, lane updates, pulse timing and return codes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fn    <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_lane  <= {NCH{LANE_RST}};
      r_saved <= '0;
      r_cnt   <= '0;
      r_ret   <= RET_OK;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_rise) begin
            r_fn    <= c2s_fn;
            r_data0 <= c2s_data0[W-1:0];
            r_data1 <= c2s_data1;
          end
        end
        ST_EXEC: begin
          // Write-all ignores the channel index entirely
          if (r_fn == FN_WRALL) begin
            r_lane <= {NCH{r_data0}};
            r_ret  <= RET_OK;
          end else if (w_ch_bad) begin
            r_ret <= RET_BADCH;
          end else begin
            case (r_fn)
              FN_WRITE: begin
                r_lane[w_ch] <= r_data0;
                r_ret        <= RET_OK;
              end
              FN_READ: begin
                r_rdata <= 32'(w_dout_lane[w_ch]);
                r_ret   <= RET_OK;
              end
              FN_PULSE: begin
                r_saved      <= r_lane[w_ch];
                r_lane[w_ch] <= r_data0;
                r_cnt        <= CNT_LOAD;
              end
              default: r_ret <= RET_BADFN;
            endcase
          end
        end
        ST_PULSE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_lane[w_ch] <= r_saved;
            r_ret        <= RET_OK;
          end
        end
        default: ;
      endcase
    end
  end

  assign c2s_ack   = (r_state == ST_ACK);
  assign c2s_ret   = r_ret;
  assign c2s_rdata = r_rdata;
  assign din       = r_lane;

endmodule : drv_c2sif_bus
`default_nettype wire

// File: tb/tb_drv_c2sif_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_drv_c2sif_bus
// Brief    : Self-checking bench for drv_c2sif_bus: directed scenarios plus
//            randomized transactions against a lane-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drv_c2sif_bus;
  import c2sif_pkg::*;

  localparam int NCH       = 4;
  localparam int W         = 8;
  localparam int PULSE_LEN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              c2s_req;
  logic [7:0]        c2s_id;
  logic [7:0]        c2s_fn;
  logic [31:0]       c2s_data0;
  logic [31:0]       c2s_data1;
  logic              c2s_ack;
  logic [31:0]       c2s_ret;
  logic [31:0]       c2s_rdata;
  logic [NCH*W-1:0]  din;
  logic [NCH*W-1:0]  dout;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0]  m_lane [NCH];
  logic [31:0]   m_ret;
  logic [31:0]   m_rdata;
  logic [31:0]   q_din [$];
  bit            acked;

  always #5 clk = ~clk;

  drv_c2sif_bus #(
    .ID        (0),
    .NCH       (NCH),
    .W         (W),
    .PULSE_LEN (PULSE_LEN),
    .RST_VAL   (32'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .c2s_req   (c2s_req),
    .c2s_id    (c2s_id),
    .c2s_fn    (c2s_fn),
    .c2s_data0 (c2s_data0),
    .c2s_data1 (c2s_data1),
    .c2s_ack   (c2s_ack),
    .c2s_ret   (c2s_ret),
    .c2s_rdata (c2s_rdata),
    .din       (din),
    .dout      (dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_din();
    logic [31:0] v = '0;
    for (int k = 0; k < NCH; k++) v[k*W +: W] = m_lane[k];
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NCH; k++) m_lane[k] = '0;
    m_ret   = 32'd0;
    m_rdata = 32'd0;
  endtask

  // Apply one transaction to the model; lat is the expected number of
  // post-edge samples from raising req up to the first ack sample.
  task automatic model_apply(input logic [7:0] fn, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] dv, output int lat, output logic [31:0] pdin);
    lat  = 4;
    pdin = m_din();
    if (fn == FN_WRALL) begin
      for (int k = 0; k < NCH; k++) m_lane[k] = d0[W-1:0];
      m_ret = RET_OK;
    end else if (d1 >= NCH) begin
      m_ret = RET_BADCH;
    end else begin
      case (fn)
        FN_WRITE: begin m_lane[d1[1:0]] = d0[W-1:0]; m_ret = RET_OK; end
        FN_READ:  begin m_rdata = (dv >> (d1 * W)) & 32'hFF; m_ret = RET_OK; end
        FN_PULSE: begin pdin[d1*W +: W] = d0[W-1:0]; lat = 4 + PULSE_LEN; m_ret = RET_OK; end
        default:  m_ret = RET_BADFN;
      endcase
    end
  endtask

  // Raise req with the given fields and sample din each cycle until ack
  task automatic txn(input logic [7:0] id, input logic [7:0] fn, input logic [31:0] d0,
                     input logic [31:0] d1, input int maxc, output bit got);
    c2s_id    = id;
    c2s_fn    = fn;
    c2s_data0 = d0;
    c2s_data1 = d1;
    c2s_req   = 1'b1;
    got       = 1'b0;
    q_din.delete();
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge clk); #1;
      q_din.push_back(din);
      if (c2s_ack === 1'b1) got = 1'b1;
    end
  endtask

  task automatic drop_req(input string tag);
    c2s_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk(tag, {31'd0, c2s_ack}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] pdin;
    logic [31:0] pre;
    int          npulse;
    bit          saw_ack;

    m_reset();
    rst = 1'b0; c2s_req = 1'b0; c2s_id = '0; c2s_fn = '0;
    c2s_data0 = '0; c2s_data1 = '0; dout = '0;

    // Reset held with random traffic on all inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      c2s_req = 1'($urandom); c2s_id = 8'($urandom); c2s_fn = 8'($urandom);
      c2s_data0 = $urandom; c2s_data1 = $urandom; dout = $urandom;
    end
    @(posedge clk); #1;
    chk("rst_din",   din, 32'd0);
    chk("rst_ack",   {31'd0, c2s_ack}, 32'd0);
    chk("rst_ret",   c2s_ret, 32'd0);
    chk("rst_rdata", c2s_rdata, 32'd0);

    // Release with req low: nothing happens
    c2s_req = 1'b0; c2s_id = 8'd0;
    rst = 1'b1;
    saw_ack = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (c2s_ack === 1'b1) saw_ack = 1'b1; end
    chk("release_no_ack", {31'd0, saw_ack}, 32'd0);

    // WRITE lane 2
    model_apply(FN_WRITE, 32'h1A5, 32'd2, dout, lat, pdin);
    txn(8'd0, FN_WRITE, 32'h1A5, 32'd2, 20, acked);
    chk("wr_ack", {31'd0, acked}, 32'd1);
    chk("wr_lat", 32'(q_din.size()), 32'(lat));
    chk("wr_din", din, 32'h00A5_0000);
    chk("wr_ret", c2s_ret, RET_OK);
    drop_req("wr_ack_fall");

    // READ lane 1 of dout
    dout = 32'hC3C3_3C96;
    pre  = m_din();
    model_apply(FN_READ, $urandom, 32'd1, dout, lat, pdin);
    txn(8'd0, FN_READ, 32'h0, 32'd1, 20, acked);
    chk("rd_ack",   {31'd0, acked}, 32'd1);
    chk("rd_rdata", c2s_rdata, 32'h0000_003C);
    chk("rd_ret",   c2s_ret, RET_OK);
    chk("rd_din",   din, pre);
    drop_req("rd_ack_fall");

    // PULSE lane 0: preload 0x11, then pulse 0xFF
    model_apply(FN_WRITE, 32'h11, 32'd0, dout, lat, pdin);
    txn(8'd0, FN_WRITE, 32'h11, 32'd0, 20, acked);
    chk("pre_din", din, m_din());
    drop_req("pre_ack_fall");
    model_apply(FN_PULSE, 32'hFF, 32'd0, dout, lat, pdin);
    txn(8'd0, FN_PULSE, 32'hFF, 32'd0, 30, acked);
    npulse = 0;
    foreach (q_din[i]) if (q_din[i][7:0] == 8'hFF) npulse++;
    chk("pulse_ack",     {31'd0, acked}, 32'd1);
    chk("pulse_len",     32'(npulse), 32'(PULSE_LEN));
    chk("pulse_lat",     32'(q_din.size()), 32'(lat));
    chk("pulse_restore", din, m_din());
    chk("pulse_ret",     c2s_ret, RET_OK);
    if (q_din.size() >= 2) chk("pulse_last", q_din[q_din.size()-2], pdin);
    drop_req("pulse_ack_fall");

    // Foreign id: ignored
    pre = m_din();
    txn(8'd1, FN_WRITE, $urandom, 32'd1, 20, acked);
    chk("id1_no_ack", {31'd0, acked}, 32'd0);
    chk("id1_din",    din, pre);
    drop_req("id1_drop");

    // Bad function code
    model_apply(8'd7, $urandom, 32'd1, dout, lat, pdin);
    txn(8'd0, 8'd7, 32'hDEAD_BEEF, 32'd1, 20, acked);
    chk("badfn_ret", c2s_ret, RET_BADFN);
    chk("badfn_din", din, m_din());
    drop_req("badfn_ack_fall");

    // Bad channel
    model_apply(FN_WRITE, 32'h77, 32'd4, dout, lat, pdin);
    txn(8'd0, FN_WRITE, 32'h77, 32'd4, 20, acked);
    chk("badch_ret", c2s_ret, RET_BADCH);
    chk("badch_din", din, m_din());
    drop_req("badch_ack_fall");

    // Write-all
    model_apply(FN_WRALL, 32'h5A, 32'd9, dout, lat, pdin);
    txn(8'd0, FN_WRALL, 32'h5A, 32'd9, 20, acked);
    chk("wrall_din", din, 32'h5A5A_5A5A);
    chk("wrall_ret", c2s_ret, RET_OK);
    drop_req("wrall_ack_fall");

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      int          kind;
      logic [7:0]  fn;
      logic [31:0] d0;
      logic [31:0] d1;
      kind = $urandom_range(0, 5);
      fn   = (kind < 4) ? 8'(kind) : 8'($urandom_range(4, 255));
      d0   = $urandom;
      d1   = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 5));
      dout = $urandom;
      model_apply(fn, d0, d1, dout, lat, pdin);
      txn(8'd0, fn, d0, d1, 30, acked);
      chk("rnd_ack", {31'd0, acked}, 32'd1);
      chk("rnd_lat", 32'(q_din.size()), 32'(lat));
      chk("rnd_din", din, m_din());
      chk("rnd_ret", c2s_ret, m_ret);
      if (fn == FN_READ && d1 < NCH) chk("rnd_rdata", c2s_rdata, m_rdata);
      if (fn == FN_PULSE && d1 < NCH)
        for (int i = 3; i < 3 + PULSE_LEN && i < q_din.size(); i++) chk("rnd_pulse", q_din[i], pdin);
      drop_req("rnd_ack_fall");
    end

    // Reset asserted in the second pulse cycle
    c2s_id = 8'd0; c2s_fn = FN_PULSE; c2s_data0 = 32'h3C; c2s_data1 = 32'd1;
    c2s_req = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    m_reset();
    chk("midrst_din", din, 32'd0);
    chk("midrst_ack", {31'd0, c2s_ack}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    saw_ack = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (c2s_ack === 1'b1) saw_ack = 1'b1; end
    chk("held_req_no_ack", {31'd0, saw_ack}, 32'd0);
    chk("held_req_din",    din, 32'd0);
    drop_req("held_req_drop");

    model_apply(FN_WRITE, 32'hC7, 32'd3, dout, lat, pdin);
    txn(8'd0, FN_WRITE, 32'hC7, 32'd3, 20, acked);
    chk("post_ack", {31'd0, acked}, 32'd1);
    chk("post_din", din, m_din());
    chk("post_ret", c2s_ret, RET_OK);
    drop_req("post_ack_fall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_drv_c2sif_bus
`default_nettype wire

// File: doc/drv_c2sif_bus.md
Name: drv_c2sif_bus

Overview:
- Parametrised successor to the single-bit c2sif driver: a clocked RTL bridge that takes c2sif request packets addressed to its ID and drives NCH output lanes of W bits each.
- Adds read-back of a DUT output bus, a timed pulse mode, write-all and error return codes.
- Sits between the C-side c2sif transactor and a DUT, one instance per driver ID.

Parameters:
- ID, 0: c2sif id this instance answers; other ids are ignored.
- NCH, 4: number of channels (1..256).
- W, 8: bits per channel (1..32).
- PULSE_LEN, 4: cycles a pulse value is held (>=1).
- RST_VAL, 0: W-bit reset/initial value of every lane.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- c2s_req  in  1  request from C side; asynchronous to clk.
- c2s_id  in  8  target id; stable while c2s_req=1.
- c2s_fn  in  8  function code.
- c2s_data0  in  32  write value; low W bits used.
- c2s_data1  in  32  channel index.
- c2s_ack  out  1  acknowledge.
- c2s_ret  out  32  return code; valid while c2s_ack=1.
- c2s_rdata  out  32  read data, zero-extended; valid while c2s_ack=1.
- din  out  NCH*W  drive lanes to DUT; lane k = din[k*W +: W].
- dout  in  NCH*W  DUT outputs; asynchronous, read back per lane.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; c2s_ack=0; c2s_ret=0; c2s_rdata=0; all lanes=RST_VAL; pulse counter=0; synchroniser flops=0.
- c2s_req and dout each pass through a 2-flop synchroniser, giving req_s and dout_s.
- A request is the rising edge of req_s: req_s=1 while its previous value was 0. A req held high across reset release is not a request.
- FSM states: IDLE, EXEC, PULSE, ACK, IGNORE.
- IDLE: on a request, latch id/fn/data0/data1.
  - id==ID -> EXEC.
  - otherwise -> IGNORE.
- IGNORE: ack stays 0; stay until req_s=0, then -> IDLE.
- EXEC (one cycle): if ch (data1) >= NCH, ret=2, no lane change, -> ACK. Otherwise, by fn:
  - 0 WRITE: lane[ch]<=data0[W-1:0]; ret=0; -> ACK.
  - 1 READ: rdata<=zero-extended dout_s lane[ch]; ret=0; -> ACK.
  - 2 PULSE: save lane[ch]; lane[ch]<=data0[W-1:0]; counter<=PULSE_LEN-1; -> PULSE.
  - 3 WRALL: every lane<=data0[W-1:0]; ch is not checked; ret=0; -> ACK.
  - any other fn: ret=1; no change; -> ACK.
- PULSE:
  - counter!=0: decrement.
  - counter==0: restore saved value; ret=0; -> ACK.
  - The pulse value is on din for exactly PULSE_LEN cycles.
- ACK: c2s_ack=1 (decoded from the state register); stay until req_s=0, then ack=0 -> IDLE. ret and rdata hold until the next EXEC.
- Latency: a new din value is visible in the first ACK cycle. That is 2 clk after the IDLE request cycle for WRITE/WRALL, and PULSE_LEN+2 clk for PULSE, where ack coincides with the restored value. Ack falls at most 3 clk after c2s_req falls.
- Requests cannot overlap: a new request is only accepted in IDLE, and one held across ACK is not re-seen.
- Reset during EXEC, PULSE or ACK: all lanes go to RST_VAL, no restore occurs, and ack drops immediately.
- dout is sampled only on READ; din is registered, so there is no combinational path from c2s_* to din.

Decomposition:
- Package c2sif_pkg holds:
  - fn codes: FN_WRITE=0, FN_READ=1, FN_PULSE=2, FN_WRALL=3.
  - ret codes: RET_OK=0, RET_BADFN=1, RET_BADCH=2.
  - state enum drv_state_t.
- Sub-module c2sif_sync: a parametrised-width 2-stage synchroniser with async active-low reset. Instantiated for req (width 1) and dout (width NCH*W).

Test Plan:
- Default parameters. Hold rst=0 with random inputs -> din=0, c2s_ack=0, c2s_ret=0. Release rst -> no ack occurs.
- WRITE: id=0, fn=0, data0=0x1A5, data1=2 -> in the first ack=1 cycle din[23:16]=0xA5 and other lanes=0x00, ret=0. Drop req -> ack=0 within 3 clk.
- READ: dout[15:8]=0x3C, fn=1, data1=1 -> rdata=0x0000003C, ret=0, din unchanged.
- PULSE: lane0=0x11, fn=2, data0=0xFF, data1=0 -> din[7:0]=0xFF for exactly 4 clk, then 0x11. Ack is first high in the cycle lane0 returns to 0x11.
- Errors:
  - id=1 -> ack never rises within 20 clk, din unchanged.
  - fn=7 -> ret=1.
  - data1=4 -> ret=2, din unchanged.
  - fn=3, data0=0x5A -> din=0x5A5A5A5A, ret=0.
- Reset mid-pulse: rst=0 in the 2nd pulse cycle -> din=0 and ack=0 at once. req held high through release -> no ack. Toggle req low/high with a WRITE -> processed normally.
